// File: rtl/bus_log_ram_ctrl.sv
// bus_log_ram_ctrl: capture/readback controller for the bus logger trace RAM.
// The trace RAM is used as a circular pre-trigger buffer, and a programmable
// number of post-trigger entries are counted after the trigger. Capture always
// has priority on the single RAM port. Host reads get the port only in idle
// cycles.
// Optional feature macro: LOGCTRL_HOST_LIVE_READ_EN. When it is defined, host
// reads are also granted while capturing (ARMED/POST).
module bus_log_ram_ctrl #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 28
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              arm,
  input  logic              trig,
  input  logic [ADDR_W-1:0] post_count,
  input  logic              cap_valid,
  input  logic [DATA_W-1:0] cap_data,
  output logic              cap_ready,
  input  logic              host_req,
  input  logic [ADDR_W-1:0] host_index,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rdata_en,
  output logic [1:0]        state,
  output logic              wrapped,
  output logic [ADDR_W:0]   level,
  output logic [ADDR_W-1:0] trig_addr,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_valid,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_rdata_en
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W:0]   DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] LAST  = '1;

  state_t              state_reg;
  logic [ADDR_W-1:0]   wptr_reg;
  logic [ADDR_W-1:0]   rem_reg;
  logic [ADDR_W-1:0]   trig_addr_reg;
  logic [ADDR_W:0]     level_reg;
  logic                wrapped_reg;

  // Read pipeline: s1 = RAM request cycle, s2 = RAM response cycle,
  // host_rdata_en_reg = data return cycle.
  logic                rd_s1_reg, rd_s2_reg;
  logic                oob_s1_reg, oob_s2_reg;
  logic                host_ack_reg;
  logic                host_rdata_en_reg;
  logic [DATA_W-1:0]   host_rdata_reg;
  logic                ram_valid_reg, ram_write_reg;
  logic [ADDR_W-1:0]   ram_address_reg;
  logic [DATA_W-1:0]   ram_wdata_reg;

  logic                trig_zero_drop;
  logic                cap_accept;
  logic                outstanding;
  logic                host_allowed;
  logic                grant;
  logic                rd_oob;
  logic [ADDR_W-1:0]   rd_addr;
  logic [ADDR_W-1:0]   rem_after_trig;

  // A trigger with zero post entries finishes the capture without taking the
  // same-cycle entry, so the handshake must refuse it as well.
  assign trig_zero_drop = (state_reg == S_ARMED) && trig && (post_count == '0);
  assign cap_ready      = !arm && !trig_zero_drop &&
                          ((state_reg == S_ARMED) ||
                           ((state_reg == S_POST) && (rem_reg != '0)));
  assign cap_accept     = cap_valid && cap_ready;
  assign outstanding    = rd_s1_reg || rd_s2_reg || host_rdata_en_reg;

`ifdef LOGCTRL_HOST_LIVE_READ_EN
  assign host_allowed = 1'b1;
`else
  // An arm cycle would move us into ARMED before the read is issued.
  assign host_allowed = !arm && ((state_reg == S_IDLE) || (state_reg == S_DONE));
`endif

  assign grant          = host_req && !cap_accept && !outstanding && host_allowed;
  // Index 0 is the oldest stored entry: slot 0 until the buffer wraps, then wptr.
  assign rd_addr        = (wrapped_reg ? wptr_reg : '0) + host_index;
  assign rd_oob         = ({1'b0, host_index} >= level_reg);
  assign rem_after_trig = post_count - ADDR_W'(cap_accept);

  // Capture FSM: pointers, level, wrap flag, trigger address and post counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      wptr_reg      <= '0;
      rem_reg       <= '0;
      trig_addr_reg <= '0;
      level_reg     <= '0;
      wrapped_reg   <= 1'b0;
    end else if (arm) begin
      state_reg     <= S_ARMED;
      wptr_reg      <= '0;
      rem_reg       <= '0;
      trig_addr_reg <= '0;
      level_reg     <= '0;
      wrapped_reg   <= 1'b0;
    end else begin
      if (cap_accept) begin
        wptr_reg <= wptr_reg + 1'b1;
        if (level_reg != DEPTH) level_reg <= level_reg + 1'b1;
        if (wptr_reg == LAST) wrapped_reg <= 1'b1;
      end
      case (state_reg)
        S_ARMED: begin
          if (trig) begin
            trig_addr_reg <= wptr_reg;
            if (post_count == '0) begin
              rem_reg   <= '0;
              state_reg <= S_DONE;
            end else begin
              rem_reg   <= rem_after_trig;
              state_reg <= (rem_after_trig == '0) ? S_DONE : S_POST;
            end
          end
        end
        S_POST: begin
          if (cap_accept) begin
            rem_reg <= rem_reg - 1'b1;
            if (rem_reg == ADDR_W'(1)) state_reg <= S_DONE;
          end
        end
        default: ;
      endcase
    end
  end

  // RAM request register and host read pipeline; arm does not cancel a read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_valid_reg     <= 1'b0;
      ram_write_reg     <= 1'b0;
      ram_address_reg   <= '0;
      ram_wdata_reg     <= '0;
      host_ack_reg      <= 1'b0;
      rd_s1_reg         <= 1'b0;
      rd_s2_reg         <= 1'b0;
      oob_s1_reg        <= 1'b0;
      oob_s2_reg        <= 1'b0;
      host_rdata_en_reg <= 1'b0;
      host_rdata_reg    <= '0;
    end else begin
      ram_valid_reg <= cap_accept || (grant && !rd_oob);
      ram_write_reg <= cap_accept;
      if (cap_accept) begin
        ram_address_reg <= wptr_reg;
        ram_wdata_reg   <= cap_data;
      end else if (grant && !rd_oob) begin
        ram_address_reg <= rd_addr;
      end
      host_ack_reg      <= grant;
      rd_s1_reg         <= grant;
      oob_s1_reg        <= rd_oob;
      rd_s2_reg         <= rd_s1_reg;
      oob_s2_reg        <= oob_s1_reg;
      host_rdata_en_reg <= rd_s2_reg;
      host_rdata_reg    <= (rd_s2_reg && !oob_s2_reg && ram_rdata_en) ? ram_rdata : '0;
    end
  end

  assign state         = state_reg;
  assign wrapped       = wrapped_reg;
  assign level         = level_reg;
  assign trig_addr     = trig_addr_reg;
  assign host_ack      = host_ack_reg;
  assign host_rdata    = host_rdata_reg;
  assign host_rdata_en = host_rdata_en_reg;
  assign ram_valid     = ram_valid_reg;
  assign ram_write     = ram_write_reg;
  assign ram_address   = ram_address_reg;
  assign ram_wdata     = ram_wdata_reg;

endmodule

// File: tb/tb_bus_log_ram_ctrl.sv
// Testbench for bus_log_ram_ctrl: directed capture sequences with a behavioural
// trace RAM; host read expectations go to a scoreboard queue that a negedge
// monitor checks at ack and at data return.
module tb_bus_log_ram_ctrl;
  localparam int AW = 12;
  localparam int DW = 28;

  logic          clk = 1'b0;
  logic          reset;
  logic          arm, trig, cap_valid, host_req;
  logic [AW-1:0] post_count, host_index;
  logic [DW-1:0] cap_data;
  logic          cap_ready, host_ack, host_rdata_en;
  logic [DW-1:0] host_rdata;
  logic [1:0]    state;
  logic          wrapped;
  logic [AW:0]   level;
  logic [AW-1:0] trig_addr, ram_address;
  logic          ram_valid, ram_write;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;
  logic          ram_rdata_en = 1'b0;

  bus_log_ram_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .arm(arm), .trig(trig), .post_count(post_count),
    .cap_valid(cap_valid), .cap_data(cap_data), .cap_ready(cap_ready),
    .host_req(host_req), .host_index(host_index), .host_ack(host_ack),
    .host_rdata(host_rdata), .host_rdata_en(host_rdata_en), .state(state),
    .wrapped(wrapped), .level(level), .trig_addr(trig_addr),
    .ram_address(ram_address), .ram_valid(ram_valid), .ram_write(ram_write),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_rdata_en(ram_rdata_en)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ack_cyc = 0;
  int rden_count = 0;

  typedef struct {
    logic [DW-1:0] data;
    bit            access;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  // Trace RAM model: one-cycle read latency.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_valid && ram_write) mem[ram_address] <= ram_wdata;
    ram_rdata_en <= ram_valid && !ram_write;
    ram_rdata    <= mem[ram_address];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // Scoreboard monitor: ack must match the expected RAM access; data must match
  // and arrive two cycles after ack.
  always @(negedge clk) begin
    if (host_ack) begin
      ack_cyc = cyc;
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL ack_unexpected: got host_ack=1 expected 0");
      end else begin
        check("ack_ram_valid", ram_valid, sb[0].access);
        if (sb[0].access) check("ack_ram_write", ram_write, 0);
      end
    end
    if (host_rdata_en) begin
      rden_count++;
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL rdata_unexpected: got host_rdata_en=1 data=0x%0h expected none", host_rdata);
      end else begin
        mon_e = sb.pop_front();
        check("rdata", host_rdata, mon_e.data);
        check("rdata_latency", cyc, ack_cyc + 2);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req_until_ack(input logic [AW-1:0] idx, input logic [DW-1:0] d, input bit acc);
    exp_t e;
    bit got;
    e.data = d; e.access = acc;
    sb.push_back(e);
    host_index = idx;
    host_req = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      step();
      if (host_ack) got = 1'b1;
    end
    host_req = 1'b0;
    if (!got) begin
      checks++; failures++;
      $display("FAIL host_ack_timeout: got no ack expected ack within 50 cycles idx=%0d", idx);
      void'(sb.pop_back());
    end
  endtask

  task automatic host_read(input logic [AW-1:0] idx, input logic [DW-1:0] d, input bit acc);
    req_until_ack(idx, d, acc);
    repeat (3) step();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_status"}, {state, wrapped, level, trig_addr, cap_ready, host_ack,
                             host_rdata_en, ram_valid, ram_write}, 0);
    check({tag, "_data"}, {host_rdata, ram_wdata}, 0);
    check({tag, "_addr"}, ram_address, 0);
  endtask

  // Asynchronous reset mid-cycle; any pending read must never return.
  task automatic reset_pulse(input string tag, input bit read_pending);
    int base;
    reset = 1'b1;
    #1;
    if (read_pending && sb.size() != 0) void'(sb.pop_back());
    check_all_zero(tag);
    base = rden_count;
    step();
    reset = 1'b0;
    repeat (4) step();
    check({tag, "_no_rdata"}, rden_count - base, 0);
  endtask

  task automatic do_arm();
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  int acks;

  initial begin
    reset = 1'b1; arm = 0; trig = 0; cap_valid = 0; host_req = 0;
    post_count = '0; host_index = '0; cap_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;
    step();

    // Pre-trigger 10 entries, trigger with post_count=5 on the 11th, 15 total.
    do_arm();
    check("arm_state", state, 1);
    for (int i = 0; i < 15; i++) begin
      cap_valid = 1'b1;
      cap_data  = DW'(32'h100 + i);
      trig      = (i == 10);
      post_count = 5;
      step();
    end
    trig = 0; cap_valid = 0;
    check("t1_state", state, 3);
    check("t1_level", level, 15);
    check("t1_trig_addr", trig_addr, 10);
    check("t1_wrapped", wrapped, 0);
    cap_valid = 1'b1; cap_data = DW'(32'h1FF);
    #1;
    check("t1_refuse_ready", cap_ready, 0);
    step();
    cap_valid = 1'b0;
    check("t1_level_after_refuse", level, 15);
    host_read(0, DW'(32'h100), 1);
    host_read(14, DW'(32'h10E), 1);
    host_read(15, '0, 0);

    // Wrap: 4100 entries without trigger.
    do_arm();
    for (int i = 0; i < 4100; i++) begin
      cap_valid = 1'b1;
      cap_data  = DW'(i);
      step();
    end
    cap_valid = 1'b0;
    check("t2_wrapped", wrapped, 1);
    check("t2_level", level, 4096);
    trig = 1'b1; post_count = '0;
    step();
    trig = 1'b0;
    check("t2_state", state, 3);
    check("t2_wptr_via_trig_addr", trig_addr, 4);
    host_read(0, DW'(4), 1);
    host_read(4095, DW'(4099), 1);

    // Trigger with post_count=0 and a same-cycle entry.
    do_arm();
    trig = 1'b1; post_count = '0; cap_valid = 1'b1; cap_data = DW'(32'hABC);
    #1;
    check("t3_ready", cap_ready, 0);
    step();
    trig = 1'b0; cap_valid = 1'b0;
    check("t3_state", state, 3);
    check("t3_level", level, 0);
    check("t3_trig_addr", trig_addr, 0);
    check("t3_no_write", ram_valid, 0);
    host_read(0, '0, 0);

    // Out-of-range index in DONE with level=3.
    do_arm();
    for (int i = 0; i < 3; i++) begin
      cap_valid = 1'b1; cap_data = DW'(32'h7A + i);
      step();
    end
    cap_valid = 1'b0;
    trig = 1'b1; post_count = '0;
    step();
    trig = 1'b0;
    check("t4_level", level, 3);
    host_read(7, '0, 0);
    host_read(2, DW'(32'h7C), 1);

    // Host request during continuous capture.
    do_arm();
    begin
      exp_t e;
      e.data = DW'(32'h500); e.access = 1'b1;
      sb.push_back(e);
    end
    host_index = '0; host_req = 1'b1; acks = 0;
    for (int i = 0; i < 20; i++) begin
      cap_valid = 1'b1; cap_data = DW'(32'h500 + i);
      step();
      if (host_ack) acks++;
    end
    cap_valid = 1'b0;
    check("t5_stream_no_grant", acks, 0);
`ifdef LOGCTRL_HOST_LIVE_READ_EN
    step();
    check("t5_live_ack", host_ack, 1);
    host_req = 1'b0;
`else
    for (int i = 0; i < 5; i++) begin
      step();
      if (host_ack) acks++;
    end
    check("t5_armed_no_grant", acks, 0);
    trig = 1'b1; post_count = '0;
    step();
    trig = 1'b0;
    check("t5_done_state", state, 3);
    check("t5_no_ack_yet", host_ack, 0);
    step();
    check("t5_done_ack", host_ack, 1);
    host_req = 1'b0;
`endif
    repeat (3) step();

    // Reset in POST (with a read outstanding when live reads are enabled).
    do_arm();
    trig = 1'b1; post_count = AW'(100);
    step();
    trig = 1'b0;
    check("t6_post_state", state, 2);
`ifdef LOGCTRL_HOST_LIVE_READ_EN
    req_until_ack(0, '0, 0);
    reset_pulse("t6_rst_post_read", 1);
`else
    reset_pulse("t6_rst_post", 0);
    do_arm();
    trig = 1'b1; post_count = '0;
    step();
    trig = 1'b0;
    req_until_ack(0, '0, 0);
    reset_pulse("t6_rst_done_read", 1);
`endif
    do_arm();
    check("t6_rearm_state", state, 1);
    for (int i = 0; i < 2; i++) begin
      cap_valid = 1'b1; cap_data = DW'(32'h900 + i);
      step();
    end
    cap_valid = 1'b0;
    check("t6_rearm_level", level, 2);
    check("t6_sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule
